// File: rtl/relm_div_seq_if.sv
// ---------------------------------------------------------------------------
// relm_div_seq_if
//   Bundles every non-clock, non-reset signal of the sequential divider:
//   the host request/result bus and the link to the external custom datapath.
//
//   Parameters
//     WD   datapath word width
//     WOP  custom datapath opcode width
//
//   Host side      : start_in, n_in, d_in -> busy_out, done_out,
//                    quot_out, rem_out, dz_out
//   Datapath side  : op_out, opb_out, xsel_out, a_out, xb_out, cb_out ->
//                    a_in, cb_in, mul_a_in, mul_x_in -> mul_ax_out
//
//   Modports
//     slave   the divider itself
//     master  the environment (host plus datapath)
// ---------------------------------------------------------------------------
interface relm_div_seq_if #(
    parameter int WD  = 32,
    parameter int WOP = 5
);
    logic              start_in;
    logic [WD-1:0]     n_in;
    logic [WD-1:0]     d_in;
    logic              busy_out;
    logic              done_out;
    logic [WD-1:0]     quot_out;
    logic [WD-1:0]     rem_out;
    logic              dz_out;
    logic [WOP-1:0]    op_out;
    logic              opb_out;
    logic [1:0]        xsel_out;
    logic [WD-1:0]     a_out;
    logic [WD-1:0]     xb_out;
    logic [3*WD-1:0]   cb_out;
    logic [WD-1:0]     a_in;
    logic [3*WD-1:0]   cb_in;
    logic [WD-1:0]     mul_a_in;
    logic [WD-1:0]     mul_x_in;
    logic [2*WD-1:0]   mul_ax_out;

    modport slave (
        input  start_in, n_in, d_in, a_in, cb_in, mul_a_in, mul_x_in,
        output busy_out, done_out, quot_out, rem_out, dz_out,
               op_out, opb_out, xsel_out, a_out, xb_out, cb_out, mul_ax_out
    );

    modport master (
        output start_in, n_in, d_in, a_in, cb_in, mul_a_in, mul_x_in,
        input  busy_out, done_out, quot_out, rem_out, dz_out,
               op_out, opb_out, xsel_out, a_out, xb_out, cb_out, mul_ax_out
    );
endinterface

// File: rtl/relm_div_seq.sv
// ---------------------------------------------------------------------------
// relm_div_seq
//   Sequential unsigned divider that sequences an external custom datapath.
//   This block owns the control FSM and the operand registers A, XB and
//   {D,C,B}; the datapath does the arithmetic and hands results back on
//   a_in / cb_in, which are registered here state by state.
//
//   Ports
//     clk            sole clock, rising edge
//     rst            asynchronous active-high reset
//     bus (slave)    relm_div_seq_if: start_in, n_in, d_in in;
//                    busy_out, done_out, quot_out, rem_out, dz_out out;
//                    op_out, opb_out, xsel_out, a_out, xb_out, cb_out to
//                    the datapath; a_in, cb_in, mul_a_in, mul_x_in from it;
//                    mul_ax_out = mul_a_in * mul_x_in (combinational)
//
//   Optional feature macro
//     RELM_DIV_SEQ_DIVZERO_EN  short-circuit divide-by-zero: IDLE->DONE,
//                              quotient all ones, remainder = dividend,
//                              dz_out = 1. Undefined: dz_out is tied low and
//                              a zero divisor flows through the normal path.
// ---------------------------------------------------------------------------
module relm_div_seq #(
    parameter int WD  = 32,
    parameter int WOP = 5
) (
    input  logic          clk,
    input  logic          rst,
    relm_div_seq_if.slave bus
);
    localparam int IW = (WD > 1) ? $clog2(WD) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIV,
        S_PREP,
        S_INIT,
        S_LOOP,
        S_MOD,
        S_DONE
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic [WD-1:0] a_q;
    logic [WD-1:0] xb_q;
    logic [WD-1:0] d_q;
    logic [WD-1:0] c_q;
    logic [WD-1:0] b_q;
    logic [WD-1:0] quot_q;
    logic [WD-1:0] rem_q;
    logic [WD-1:0] prep_a;
    logic [IW-1:0] b_idx;
    logic          start_dz;

`ifdef RELM_DIV_SEQ_DIVZERO_EN
    logic          dz_q;
    assign start_dz = bus.start_in && (bus.d_in == '0);
`else
    assign start_dz = 1'b0;
`endif

    // B holds the one-hot MSB of the divisor and A the one-hot MSB of the
    // dividend; shifting A down by B's bit position yields a one-hot marker
    // of the highest quotient bit. No quotient bits exist when the divisor
    // MSB is above the dividend MSB or the divisor is zero.
    always_comb begin
        b_idx = '0;
        for (int i = 0; i < WD; i++) begin
            if (b_q[i]) begin
                b_idx = i[IW-1:0];
            end
        end
        prep_a = ((b_q == '0) || (b_q > a_q)) ? '0 : (a_q >> b_idx);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and datapath control. The LOOP exit looks at the
    // value being registered into A so the FSM leaves on the same edge at
    // which A becomes zero.
    always_comb begin
        state_d      = state_q;
        bus.opb_out  = 1'b0;
        bus.xsel_out = 2'b00;
        bus.op_out   = '0;
        if (state_q != S_IDLE) begin
            bus.op_out[2:0] = 3'b101;
        end
        unique case (state_q)
            S_IDLE: begin
                if (bus.start_in) begin
                    state_d = start_dz ? S_DONE : S_DIV;
                end
            end
            S_DIV: begin
                state_d = S_PREP;
            end
            S_PREP: begin
                state_d = S_INIT;
            end
            S_INIT: begin
                bus.opb_out  = 1'b1;
                bus.xsel_out = 2'b10;
                state_d      = (a_q != '0) ? S_LOOP : S_MOD;
            end
            S_LOOP: begin
                bus.opb_out  = 1'b1;
                bus.xsel_out = 2'b01;
                if (bus.a_in == '0) begin
                    state_d = S_MOD;
                end
            end
            S_MOD: begin
                bus.opb_out  = 1'b1;
                bus.xsel_out = 2'b11;
                state_d      = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operand and result registers. Results only change at the end of MOD
    // (or on a short-circuited divide-by-zero start), so a reset in the
    // middle of an operation leaves nothing half-written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            xb_q   <= '0;
            d_q    <= '0;
            c_q    <= '0;
            b_q    <= '0;
            quot_q <= '0;
            rem_q  <= '0;
`ifdef RELM_DIV_SEQ_DIVZERO_EN
            dz_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start_in) begin
                        a_q  <= bus.n_in;
                        xb_q <= bus.d_in;
`ifdef RELM_DIV_SEQ_DIVZERO_EN
                        if (start_dz) begin
                            quot_q <= '1;
                            rem_q  <= bus.n_in;
                            dz_q   <= 1'b1;
                        end
`endif
                    end
                end
                S_DIV: begin
                    a_q               <= bus.a_in;
                    {d_q, c_q, b_q}   <= bus.cb_in;
                end
                S_PREP: begin
                    a_q <= prep_a;
                end
                S_INIT: begin
                    {d_q, c_q, b_q}   <= bus.cb_in;
                end
                S_LOOP: begin
                    a_q               <= bus.a_in;
                    {d_q, c_q, b_q}   <= bus.cb_in;
                end
                S_MOD: begin
                    quot_q <= b_q;
                    rem_q  <= bus.a_in;
`ifdef RELM_DIV_SEQ_DIVZERO_EN
                    dz_q   <= 1'b0;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy_out   = (state_q != S_IDLE);
    assign bus.done_out   = (state_q == S_DONE);
    assign bus.quot_out   = quot_q;
    assign bus.rem_out    = rem_q;
    assign bus.a_out      = a_q;
    assign bus.xb_out     = xb_q;
    assign bus.cb_out     = {d_q, c_q, b_q};
    assign bus.mul_ax_out = {{WD{1'b0}}, bus.mul_a_in} * {{WD{1'b0}}, bus.mul_x_in};

`ifdef RELM_DIV_SEQ_DIVZERO_EN
    assign bus.dz_out = dz_q;
`else
    assign bus.dz_out = 1'b0;
`endif

endmodule

// File: tb/tb_relm_div_seq.sv
// ---------------------------------------------------------------------------
// tb_relm_div_seq
//   Testbench for relm_div_seq. Provides a behavioural model of the external
//   custom datapath (restoring division, two quotient bits per LOOP cycle)
//   and compares results against plain n/d, n%d arithmetic.
// ---------------------------------------------------------------------------
module tb_relm_div_seq;
    localparam int WD  = 32;
    localparam int WOP = 5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    relm_div_seq_if #(.WD(WD), .WOP(WOP)) bus ();

    relm_div_seq #(.WD(WD), .WOP(WOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [WD-1:0] n;
        logic [WD-1:0] d;
        logic [WD-1:0] q;
        logic [WD-1:0] r;
        logic          dz;
        int            lat;
    } vec_t;

    // Index of the highest set bit, -1 for zero.
    function automatic int ref_msb(logic [WD-1:0] x);
        int m = -1;
        for (int i = 0; i < WD; i++) begin
            if (x[i]) m = i;
        end
        return m;
    endfunction

    function automatic logic [WD-1:0] onehot_msb(logic [WD-1:0] x);
        logic [WD-1:0] r = '0;
        int m = ref_msb(x);
        if (m >= 0) r[m] = 1'b1;
        return r;
    endfunction

    // Two restoring-division steps; A marks the current quotient bit.
    function automatic logic [4*WD-1:0] dp_loop(logic [WD-1:0] a, logic [WD-1:0] dd,
                                                logic [WD-1:0] c, logic [WD-1:0] b);
        for (int s = 0; s < 2; s++) begin
            if (a != '0) begin
                if (c >= dd) begin
                    c = c - dd;
                    b = b | a;
                end
                dd = dd >> 1;
                a  = a >> 1;
            end
        end
        return {a, dd, c, b};
    endfunction

    // Reference: quotient bits needed = msb(n)-msb(d)+1, two per LOOP cycle.
    function automatic int ref_lat(logic [WD-1:0] n, logic [WD-1:0] d);
        int k;
`ifdef RELM_DIV_SEQ_DIVZERO_EN
        if (d == '0) return 2;
`endif
        if (n == '0 || d == '0) return 6;
        k = ref_msb(n) - ref_msb(d);
        if (k < 0) return 6;
        return 6 + (k + 2) / 2;
    endfunction

    function automatic vec_t ref_div(logic [WD-1:0] n, logic [WD-1:0] d);
        vec_t v;
        v.n   = n;
        v.d   = d;
        v.lat = ref_lat(n, d);
        if (d == '0) begin
`ifdef RELM_DIV_SEQ_DIVZERO_EN
            v.q  = '1;
            v.dz = 1'b1;
`else
            v.q  = '0;
            v.dz = 1'b0;
`endif
            v.r = n;
        end else begin
            v.q  = n / d;
            v.r  = n % d;
            v.dz = 1'b0;
        end
        return v;
    endfunction

    // External datapath model.
    assign bus.mul_a_in = bus.a_out;
    assign bus.mul_x_in = bus.cb_out[3*WD-1:2*WD];

    always_comb begin
        bus.a_in  = bus.a_out;
        bus.cb_in = bus.cb_out;
        if (!bus.opb_out) begin
            bus.a_in  = onehot_msb(bus.a_out);
            bus.cb_in = {bus.xb_out, bus.a_out, onehot_msb(bus.xb_out)};
        end else begin
            case (bus.xsel_out)
                2'b10: bus.cb_in = {bus.mul_ax_out[WD-1:0], bus.cb_out[2*WD-1:WD], {WD{1'b0}}};
                2'b01: {bus.a_in, bus.cb_in} = dp_loop(bus.a_out, bus.cb_out[3*WD-1:2*WD],
                                                       bus.cb_out[2*WD-1:WD], bus.cb_out[WD-1:0]);
                2'b11: bus.a_in = bus.cb_out[2*WD-1:WD];
                default: ;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues one start pulse, waits (bounded) for done, returns results,
    // the inclusive start-to-done cycle count and the done pulses seen.
    task automatic applyStimulus(input logic [WD-1:0] n, input logic [WD-1:0] d,
                                 output logic [WD-1:0] q, output logic [WD-1:0] r,
                                 output logic dz, output int lat, output int dones);
        int cyc;
        lat = 0; dones = 0; q = '0; r = '0; dz = 1'b0;
        @(negedge clk);
        bus.start_in = 1'b1; bus.n_in = n; bus.d_in = d;
        cyc = 1;
        @(negedge clk);
        bus.start_in = 1'b0;
        cyc = 2;
        while (!bus.done_out && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (bus.done_out) begin
            lat = cyc; dones = 1;
            q = bus.quot_out; r = bus.rem_out; dz = bus.dz_out;
        end
        repeat (3) begin
            @(negedge clk);
            if (bus.done_out) dones++;
        end
    endtask

    task automatic runVector(input string tag, input vec_t v);
        logic [WD-1:0] q, r;
        logic dz;
        int lat, dones;
        applyStimulus(v.n, v.d, q, r, dz, lat, dones);
        checkOutput({tag, " quot"}, 64'(q), 64'(v.q));
        checkOutput({tag, " rem"}, 64'(r), 64'(v.r));
        checkOutput({tag, " dz"}, 64'(dz), 64'(v.dz));
        checkOutput({tag, " latency"}, 64'(lat), 64'(v.lat));
        checkOutput({tag, " done pulses"}, 64'(dones), 64'd1);
        checkOutput({tag, " quot held"}, 64'(bus.quot_out), 64'(v.q));
    endtask

    initial begin
        vec_t vecs[6];
        vec_t v;
        int fd, dn, nb, b1, b2;

        vecs[0] = '{n: 32'd100,        d: 32'd7, q: 32'd14,        r: 32'd2, dz: 1'b0, lat: 9};
        vecs[1] = '{n: 32'd5,          d: 32'd9, q: 32'd0,         r: 32'd5, dz: 1'b0, lat: 6};
        vecs[2] = '{n: 32'hFFFFFFFF,   d: 32'd1, q: 32'hFFFFFFFF,  r: 32'd0, dz: 1'b0, lat: 22};
`ifdef RELM_DIV_SEQ_DIVZERO_EN
        vecs[3] = '{n: 32'd1234,       d: 32'd0, q: 32'hFFFFFFFF,  r: 32'd1234, dz: 1'b1, lat: 2};
`else
        vecs[3] = '{n: 32'd1234,       d: 32'd0, q: 32'd0,         r: 32'd1234, dz: 1'b0, lat: 6};
`endif
        vecs[4] = '{n: 32'd50,         d: 32'd5, q: 32'd10,        r: 32'd0, dz: 1'b0, lat: 8};
        vecs[5] = '{n: 32'd6,          d: 32'd6, q: 32'd1,         r: 32'd0, dz: 1'b0, lat: 7};

        bus.start_in = 1'b0; bus.n_in = '0; bus.d_in = '0;
        rst = 1'b1;
        #1;
        checkOutput("reset busy", 64'(bus.busy_out), 64'd0);
        checkOutput("reset done", 64'(bus.done_out), 64'd0);
        checkOutput("reset quot", 64'(bus.quot_out), 64'd0);
        checkOutput("reset rem", 64'(bus.rem_out), 64'd0);
        checkOutput("reset dz", 64'(bus.dz_out), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i]);
        end

        for (int i = 0; i < 24; i++) begin
            logic [WD-1:0] n, d;
            n = $urandom >> $urandom_range(0, 31);
            d = $urandom >> $urandom_range(0, 31);
            if (i % 8 == 7) d = '0;
            runVector($sformatf("rand%0d", i), ref_div(n, d));
        end

        // Reset in the middle of LOOP.
        @(negedge clk);
        bus.start_in = 1'b1; bus.n_in = 32'hFFFFFFFF; bus.d_in = 32'd1;
        @(negedge clk);
        bus.start_in = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("loop opb", 64'(bus.opb_out), 64'd1);
        checkOutput("loop xsel", 64'(bus.xsel_out), 64'd1);
        checkOutput("loop op low bits", 64'(bus.op_out[2:0]), 64'd5);
        rst = 1'b1;
        #1;
        checkOutput("midrst busy", 64'(bus.busy_out), 64'd0);
        checkOutput("midrst done", 64'(bus.done_out), 64'd0);
        checkOutput("midrst quot", 64'(bus.quot_out), 64'd0);
        checkOutput("midrst rem", 64'(bus.rem_out), 64'd0);
        checkOutput("midrst dz", 64'(bus.dz_out), 64'd0);
        checkOutput("midrst a", 64'(bus.a_out), 64'd0);
        checkOutput("midrst xb", 64'(bus.xb_out), 64'd0);
        checkOutput("midrst cb", 64'(bus.cb_out != '0), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0; nb = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done_out) dn++;
            if (bus.busy_out) nb++;
        end
        checkOutput("midrst no done", 64'(dn), 64'd0);
        checkOutput("midrst stays idle", 64'(nb), 64'd0);
        runVector("after rst 50/5", ref_div(32'd50, 32'd5));

        // start_in held high through a whole 100/7 operation.
        @(negedge clk);
        bus.start_in = 1'b1; bus.n_in = 32'd100; bus.d_in = 32'd7;
        fd = 0; dn = 0; b1 = -1; b2 = -1;
        for (int c = 2; c <= 30; c++) begin
            @(negedge clk);
            if (bus.done_out) begin
                dn++;
                if (fd == 0) fd = c;
            end
            if (fd != 0 && c == fd + 1) b1 = int'(bus.busy_out);
            if (fd != 0 && c == fd + 2) begin
                b2 = int'(bus.busy_out);
                bus.start_in = 1'b0;
            end
        end
        bus.start_in = 1'b0;
        checkOutput("held start first done cycle", 64'(fd), 64'd9);
        checkOutput("held start idle after done", 64'(b1), 64'd0);
        checkOutput("held start reaccept", 64'(b2), 64'd1);
        checkOutput("held start done count", 64'(dn), 64'd2);
        checkOutput("held start quot", 64'(bus.quot_out), 64'd14);
        checkOutput("held start rem", 64'(bus.rem_out), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
